muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Sits downstream of the ID stage and register file: consumes rs1/rs2 read data plus funct3, and produces the register write-back value.
- Asserts a stall so the PC holds while an operation is in flight; the result is valid in the cycle `done` is high, which is when the PC advances and the register file writes.

Parameters:
- XLEN, 32, operand and result width; iteration count equals XLEN.

Ports:
- clk       input   1     system clock, rising edge.
- rst       input   1     asynchronous, active-low reset.
- start     input   1     operation request; valid only when the unit is idle.
- funct3    input   3     RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input   XLEN  operand A (multiplicand or dividend).
- rs2_data  input   XLEN  operand B (multiplier or divisor).
- busy      output  1     high in CALC and DONE.
- stall     output  1     combinational: (start & state==IDLE) | (state==CALC).
- done      output  1     one-cycle pulse; result valid.
- result    output  XLEN  write-back value; held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, busy=0, done=0, result=0, internal registers cleared.
  - Asserting reset mid-operation aborts the operation; no done pulse is emitted.
- State machine (IDLE, CALC, DONE):
  - IDLE: start=1 accepts the operation at the rising edge. funct3 and operands are latched at that edge; later changes to the inputs are ignored.
    - Normal op: go to CALC, counter=XLEN-1.
    - Special case (below): go straight to DONE.
  - CALC: one radix-2 step per cycle, counter decrements. At counter==0 go to DONE.
  - DONE: done=1, result registered, go to IDLE next cycle.
- Latency, with the start cycle as cycle 0:
  - Normal op: busy in cycles 1..XLEN+1; done in cycle XLEN+1 (cycle 33 at XLEN=32).
  - Special case: done in cycle 1.
- start while busy is ignored and does not queue. start in the same cycle as done is ignored, because the state is DONE, not IDLE.
- Sign handling:
  - At accept, take the absolute value of any operand treated as signed.
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: rs1 signed only.
    - U variants: none.
  - The core computes unsigned. The final result is negated in the DONE transition when needed.
    - Product sign = signA ^ signB.
    - Quotient sign = signA ^ signB.
    - Remainder sign = signA.
- Multiply: shift-add into a 2*XLEN accumulator.
  - MUL returns low XLEN bits.
  - MULH, MULHSU, MULHU return high XLEN bits of the signed-corrected 2*XLEN product.
- Divide: restoring division, XLEN-bit quotient and remainder registers. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases, resolved at accept and bypassing CALC:
  - Divide by zero (rs2=0, any div/rem op): quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- stall falls in the DONE cycle so the PC advances exactly when the result is written.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL … F3_REMU).
  - State enum (IDLE, CALC, DONE).
  - XLEN default.
- One sub-module: div_step, combinational. It takes a partial remainder, a dividend bit and the divisor, and returns the next remainder and a quotient bit. It is instantiated once and reused every CALC cycle.
- Multiply step stays inline.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3), start pulse in cycle 0 -> stall high cycles 0..32; done only in cycle 33; result=0xFFFFFFEB; busy=0 in cycle 34.
- MULH, rs1=rs2=0x80000000 -> result 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU, rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV, rs1=100, rs2=0xFFFFFFF9 (-7) -> result 0xFFFFFFF2 (-14). REM with the same operands -> 2. DIVU, rs1=100, rs2=7 -> 14.
- DIV by zero with rs1=55 -> done in cycle 1, result 0xFFFFFFFF. REMU by zero -> 55. DIV 0x80000000 / 0xFFFFFFFF -> done in cycle 1, result 0x80000000; REM of the same -> 0.
- Start a DIV, then hold start=1 with new operands in cycles 5..10 -> ignored; the first result is unchanged at cycle 33.
- Start a MUL, drive rst=0 asynchronously at cycle 12 mid-clock, release at cycle 14 -> busy, stall, done and result are 0 immediately; no done pulse follows; a new start after release completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type, default width and operand-sign helpers.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // rs1 is treated as signed for every signed op including MULHSU
  function automatic logic op_a_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: op_a_signed = 1'b1;
      default:                                    op_a_signed = 1'b0;
    endcase
  endfunction

  // rs2 is signed only for the fully signed ops
  function automatic logic op_b_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: op_b_signed = 1'b1;
      default:                         op_b_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder and subtract the divisor if it fits. Relies on rem_i < divisor_i.
import muldiv_pkg::*;

module div_step #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  // Trial subtraction; a clear sign bit means the divisor fits
  always_comb begin
    shifted_s = {rem_i, bit_i};
    trial_s   = shifted_s - {1'b0, divisor_i};
    if (!trial_s[XLEN]) begin
      rem_o = trial_s[XLEN-1:0];
      q_o   = 1'b1;
    end else begin
      rem_o = shifted_s[XLEN-1:0];
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide execute unit. Operands are latched as
// magnitudes at accept, the core runs XLEN unsigned radix-2 steps, and the
// sign is reapplied on the transition into DONE. Divide-by-zero and signed
// overflow are resolved at accept and skip straight to DONE.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_TOP = CW'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {hi, multiplier}; div: {rem, quotient/dividend}
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sign_a_s, sign_b_s;
  logic [XLEN-1:0]   abs_a_s, abs_b_s;
  logic              is_div_s, is_rem_s, div_zero_s, ovf_s;
  logic [XLEN-1:0]   special_res_s;

  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] acc_mul_s, acc_div_s, acc_nx_s, prod_s;
  logic [XLEN-1:0]   div_rem_s, div_sel_s, div_fin_s, mul_fin_s, fin_s;
  logic              div_q_s;

  // Operand magnitudes and special-case detection from the live inputs
  always_comb begin
    sign_a_s   = op_a_signed(funct3) & rs1_data[XLEN-1];
    sign_b_s   = op_b_signed(funct3) & rs2_data[XLEN-1];
    abs_a_s    = sign_a_s ? (~rs1_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs1_data;
    abs_b_s    = sign_b_s ? (~rs2_data + {{(XLEN-1){1'b0}}, 1'b1}) : rs2_data;
    is_div_s   = funct3[2];
    is_rem_s   = funct3[2] & funct3[1];
    div_zero_s = is_div_s & (rs2_data == {XLEN{1'b0}});
    ovf_s      = is_div_s & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == {XLEN{1'b1}});
    if (div_zero_s) begin
      special_res_s = is_rem_s ? rs1_data : {XLEN{1'b1}};
    end else if (ovf_s) begin
      special_res_s = is_rem_s ? {XLEN{1'b0}} : MIN_NEG;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .bit_i     (acc_q[XLEN-1]),
    .divisor_i (opb_q),
    .rem_o     (div_rem_s),
    .q_o       (div_q_s)
  );

  // One radix-2 step of the running op, plus the sign-corrected final value
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    acc_mul_s = {mul_sum_s, acc_q[XLEN-1:1]};
    acc_div_s = {div_rem_s, acc_q[XLEN-2:0], div_q_s};
    acc_nx_s  = f3_q[2] ? acc_div_s : acc_mul_s;
    prod_s    = neg_q ? (~acc_nx_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_nx_s;
    mul_fin_s = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_sel_s = f3_q[1] ? acc_nx_s[2*XLEN-1:XLEN] : acc_nx_s[XLEN-1:0];
    div_fin_s = neg_q ? (~div_sel_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_sel_s;
    fin_s     = f3_q[2] ? div_fin_s : mul_fin_s;
  end

  // Next-state and datapath updates for IDLE/CALC/DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          f3_d  = funct3;
          neg_d = is_rem_s ? sign_a_s : (sign_a_s ^ sign_b_s);
          if (div_zero_s || ovf_s) begin
            state_d  = DONE;
            cnt_d    = {CW{1'b0}};
            result_d = special_res_s;
          end else begin
            state_d = CALC;
            cnt_d   = CNT_TOP;
            if (is_div_s) begin
              opb_d = abs_b_s;
              acc_d = {{XLEN{1'b0}}, abs_a_s};
            end else begin
              opb_d = abs_a_s;
              acc_d = {{XLEN{1'b0}}, abs_b_s};
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_nx_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = DONE;
          result_d = fin_s;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      f3_q     <= 3'b000;
      neg_q    <= 1'b0;
      opb_q    <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      result_q <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = (start & (state_q == IDLE)) | (state_q == CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-exact latency, stall/busy/done
// shape, signed/unsigned results, special cases, start-ignore and reset abort.
import muldiv_pkg::*;

module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the start cycle; checks every cycle through done and one beyond
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input bit hold_start);
    step();
    start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
    #1;
    check($sformatf("%s stall c0", tag), {31'd0, stall}, 32'd1);
    check($sformatf("%s busy c0", tag),  {31'd0, busy},  32'd0);
    for (int c = 1; c <= exp_lat; c++) begin
      step();
      if (c == 1) begin
        funct3 = ~f3; rs1_data = 32'hDEADBEEF; rs2_data = 32'h0000_0000;
      end
      if (hold_start && c >= 5 && c <= 10) begin
        start = 1'b1; funct3 = F3_DIVU; rs1_data = 32'd9; rs2_data = 32'd3;
      end else begin
        start = hold_start && (c == exp_lat);
      end
      #1;
      check($sformatf("%s busy c%0d", tag, c),  {31'd0, busy},  32'd1);
      check($sformatf("%s done c%0d", tag, c),  {31'd0, done},  {31'd0, (c == exp_lat)});
      check($sformatf("%s stall c%0d", tag, c), {31'd0, stall}, {31'd0, (c < exp_lat)});
      if (c == exp_lat) begin
        check($sformatf("%s result", tag), result, exp_res);
      end
    end
    step();
    start = 1'b0;
    #1;
    check($sformatf("%s busy after", tag),  {31'd0, busy},  32'd0);
    check($sformatf("%s done after", tag),  {31'd0, done},  32'd0);
    check($sformatf("%s stall after", tag), {31'd0, stall}, 32'd0);
    check($sformatf("%s result held", tag), result, exp_res);
  endtask

  initial begin
    int done_seen;
    rst = 1'b0; start = 1'b0; funct3 = 3'b000;
    rs1_data = 32'h0000_0000; rs2_data = 32'h0000_0000;
    #2;
    check("reset busy",   {31'd0, busy},  32'd0);
    check("reset done",   {31'd0, done},  32'd0);
    check("reset stall",  {31'd0, stall}, 32'd0);
    check("reset result", result, 32'h0000_0000);
    #20;
    rst = 1'b1;

    run_op("mul",      F3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulh",     F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    run_op("mulhu",    F3_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    run_op("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, 1'b0);
    run_op("mulhu_ff", F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("div",      F3_DIV,    32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b0);
    run_op("rem",      F3_REM,    32'd100,      32'hFFFF_FFF9, 32'd2,        33, 1'b0);
    run_op("rem_neg",  F3_REM,    32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu",     F3_DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b0);
    run_op("div_by0",  F3_DIV,    32'd55,       32'd0,        32'hFFFF_FFFF, 1,  1'b0);
    run_op("remu_by0", F3_REMU,   32'd55,       32'd0,        32'd55,       1,  1'b0);
    run_op("div_ovf",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("rem_ovf",  F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0);
    run_op("div_hold", F3_DIV,    32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b1);

    // Reset mid-operation: outputs clear at once and no done follows
    step();
    start = 1'b1; funct3 = F3_MUL; rs1_data = 32'd5; rs2_data = 32'd6;
    step();
    start = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      step();
    end
    #3;
    rst = 1'b0;
    #1;
    check("abort busy",   {31'd0, busy},  32'd0);
    check("abort stall",  {31'd0, stall}, 32'd0);
    check("abort done",   {31'd0, done},  32'd0);
    check("abort result", result, 32'h0000_0000);
    step();
    step();
    rst = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    check("abort no done", done_seen, 32'd0);
    check("abort idle",    {31'd0, busy}, 32'd0);

    run_op("mul_after", F3_MUL, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
